// File: rtl/ks_pkg.sv
// Shared constants and helpers for the Karplus-Strong audio path.
// Slot numbering: slot 0 is the left MSB and slot 2*AUDIO_DW-1 is the right LSB.
package ks_pkg;

  localparam int AUDIO_DW        = 8;
  localparam int SLOT_W          = $clog2(2*AUDIO_DW);
  localparam int WS_RISE_SLOT    = AUDIO_DW-1;
  localparam int FRAME_LAST_SLOT = 2*AUDIO_DW-1;

  function automatic int slot_width(input int dw);
    return (dw > 1) ? $clog2(2*dw) : 1;
  endfunction

  // ws leads the data by one bit, so it switches during the LSB of the previous channel
  function automatic logic ws_for_slot(input int slot, input int dw);
    return (slot >= dw-1) && (slot <= 2*dw-2);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock divider: sck toggles every SCK_HALF_DIV clk cycles while enabled,
// with single-cycle strobes marking the cycle in which sck rises or falls.
module i2s_sck_gen #(
  parameter int SCK_HALF_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int DIV_W = (SCK_HALF_DIV > 1) ? $clog2(SCK_HALF_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap     = en && (div_cnt == DIV_W'(SCK_HALF_DIV-1));
  assign sck_rise = wrap && !sck;
  assign sck_fall = wrap && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips-format I2S transmitter: a one-entry stereo holding buffer feeding a
// frame shift word, with frame and underrun strobes for the status logic.
module i2s_tx_serializer #(
  parameter int AUDIO_DW     = ks_pkg::AUDIO_DW,
  parameter int SCK_HALF_DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [AUDIO_DW-1:0] l_data_i,
  input  logic [AUDIO_DW-1:0] r_data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                sck_o,
  output logic                ws_o,
  output logic                sd_o,
  output logic                frame_o,
  output logic                underrun_o
);

  import ks_pkg::*;

  localparam int                SW        = slot_width(AUDIO_DW);
  localparam int                WW        = 2*AUDIO_DW;
  localparam logic [SW-1:0]     LAST_SLOT = SW'(WW-1);

  logic          sck_fall;
  logic          sck_rise_unused;
  logic [SW-1:0] slot, slot_nxt;
  logic [WW-1:0] word, word_nxt;
  logic [WW-1:0] buf_word;
  logic          buf_full;
  logic          load;
  logic          xfer;

  i2s_sck_gen #(
    .SCK_HALF_DIV(SCK_HALF_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_i),
    .sck      (sck_o),
    .sck_rise (sck_rise_unused),
    .sck_fall (sck_fall)
  );

  assign ready_o = en_i && !buf_full;
  assign xfer    = valid_i && ready_o;
  assign load    = sck_fall && (slot == LAST_SLOT);

  // An empty buffer at load time leaves the previous word in place, so the frame repeats
  always_comb begin
    slot_nxt = (slot == LAST_SLOT) ? '0 : slot + SW'(1);
    word_nxt = word;
    if (load && buf_full)
      word_nxt = buf_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= LAST_SLOT;
      word       <= '0;
      ws_o       <= 1'b0;
      sd_o       <= 1'b0;
      frame_o    <= 1'b0;
      underrun_o <= 1'b0;
    end else if (!en_i) begin
      slot       <= LAST_SLOT;
      word       <= '0;
      ws_o       <= 1'b0;
      sd_o       <= 1'b0;
      frame_o    <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      frame_o    <= load;
      underrun_o <= load && !buf_full;
      if (sck_fall) begin
        slot <= slot_nxt;
        word <= word_nxt;
        ws_o <= ws_for_slot(int'(slot_nxt), AUDIO_DW);
        sd_o <= word_nxt[SW'(WW-1) - slot_nxt];
      end
    end
  end

  // A transfer can only coincide with a load when the buffer is empty, so the
  // load sees the old (empty) state and the new pair waits for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_word <= '0;
      buf_full <= 1'b0;
    end else if (!en_i) begin
      buf_word <= '0;
      buf_full <= 1'b0;
    end else if (xfer) begin
      buf_word <= {l_data_i, r_data_i};
      buf_full <= 1'b1;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: an I2S receiver model decodes the
// serial stream and a frame-level model predicts what each frame must carry.
module tb_i2s_tx_serializer;

  localparam int DW    = 8;
  localparam int DIV   = 1;
  localparam int FRAME = 2*DW*2*DIV;
  localparam int RX_LAG = (2*DW-1)*2*DIV + DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] l_data_i = '0;
  logic [DW-1:0] r_data_i = '0;
  logic          ready_o, sck_o, ws_o, sd_o, frame_o, underrun_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_edge = 0;

  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; int acc; } push_t;
  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;

  push_t pushes[$];
  pair_t dec[$];
  int    ftime[$];
  bit    fflag[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_tx_serializer #(
    .AUDIO_DW     (DW),
    .SCK_HALF_DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .l_data_i   (l_data_i),
    .r_data_i   (r_data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sck_o      (sck_o),
    .ws_o       (ws_o),
    .sd_o       (sd_o),
    .frame_o    (frame_o),
    .underrun_o (underrun_o)
  );

  // Receiver: sample on sck rising; a ws change marks the LSB of the previous channel
  logic        sck_prev = 1'b0;
  logic        ws_prev = 1'b0;
  logic [15:0] sh = '0;
  logic [DW-1:0] pend_l = '0;
  bit          have_l = 1'b0;

  always @(negedge clk) begin
    if (!rst_n || !en_i) begin
      sck_prev = 1'b0;
      ws_prev  = 1'b0;
      sh       = '0;
      have_l   = 1'b0;
    end else begin
      if (frame_o) begin
        ftime.push_back(cyc);
        fflag.push_back(underrun_o);
      end
      if (sck_o && !sck_prev) begin
        sh = {sh[14:0], sd_o};
        if (ws_o != ws_prev) begin
          if (!ws_prev) begin
            pend_l = sh[DW-1:0];
            have_l = 1'b1;
          end else if (have_l) begin
            pair_t p;
            p.l = pend_l;
            p.r = sh[DW-1:0];
            dec.push_back(p);
            have_l = 1'b0;
          end
        end
        ws_prev = ws_o;
      end
      sck_prev = sck_o;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one pair and hold valid until it is taken; called and returns at a negedge
  task automatic applyStimulus(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int    waited;
    push_t p;
    waited   = 0;
    l_data_i = l;
    r_data_i = r;
    valid_i  = 1'b1;
    while (!ready_o && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) begin
      total++;
      bad++;
      $error("[TB] FAIL push_timeout: observed=ready_low expected=accept within 400 cycles");
      valid_i = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      p.l   = l;
      p.r   = r;
      p.acc = cyc;
      pushes.push_back(p);
      valid_i = 1'b0;
    end
  endtask

  task automatic waitEdge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic startPhase();
    en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dec.delete();
    ftime.delete();
    fflag.delete();
    pushes.delete();
    en_i    = 1'b1;
    en_edge = cyc + 1;
    #1;
  endtask

  // Frame k loads at a fixed cadence after enable and takes the oldest pair accepted
  // strictly before that load; with nothing pending it repeats and flags an underrun
  task automatic checkPhase(input string tag);
    push_t         pend[$];
    logic [DW-1:0] last_l, last_r;
    bit            uflag;
    int            lk, c;
    c      = cyc;
    pend   = pushes;
    last_l = '0;
    last_r = '0;
    for (int k = 0; k < 64; k++) begin
      lk = en_edge + 1 + k*FRAME;
      if (lk + RX_LAG >= c) break;
      if (pend.size() > 0 && pend[0].acc < lk) begin
        last_l = pend[0].l;
        last_r = pend[0].r;
        void'(pend.pop_front());
        uflag = 1'b0;
      end else begin
        uflag = 1'b1;
      end
      if (k < dec.size()) begin
        checkOutput($sformatf("%s_f%0d_left", tag, k), 32'(dec[k].l), 32'(last_l));
        checkOutput($sformatf("%s_f%0d_right", tag, k), 32'(dec[k].r), 32'(last_r));
      end else begin
        total++;
        bad++;
        $error("[TB] FAIL %s_f%0d_decode: observed=missing expected=frame", tag, k);
      end
      if (k < ftime.size()) begin
        checkOutput($sformatf("%s_f%0d_time", tag, k), 32'(ftime[k]), 32'(lk));
        checkOutput($sformatf("%s_f%0d_underrun", tag, k), 32'(fflag[k]), 32'(uflag));
      end else begin
        total++;
        bad++;
        $error("[TB] FAIL %s_f%0d_strobe: observed=missing expected=frame_o", tag, k);
      end
    end
  endtask

  initial begin
    int l1;
    int target;
    logic [DW-1:0] a, b;

    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_sck", 32'(sck_o), 0);
    checkOutput("rst_ws", 32'(ws_o), 0);
    checkOutput("rst_sd", 32'(sd_o), 0);
    checkOutput("rst_frame", 32'(frame_o), 0);
    checkOutput("rst_underrun", 32'(underrun_o), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_disabled", 32'(ready_o), 0);

    // Basic frame, ws timing, then underrun repeats of a single pair
    startPhase();
    applyStimulus(8'hA5, 8'h3C);
    checkOutput("A_ready_after_accept", 32'(ready_o), 0);
    checkOutput("A_first_sck_rise", 32'(sck_o), 1);
    l1 = en_edge + 1;
    @(negedge clk);
    checkOutput("A_load_cycle", 32'(cyc), 32'(l1));
    checkOutput("A_frame_pulse", 32'(frame_o), 1);
    checkOutput("A_no_underrun", 32'(underrun_o), 0);
    checkOutput("A_ready_reopen", 32'(ready_o), 1);
    checkOutput("A_slot0_ws", 32'(ws_o), 0);
    checkOutput("A_slot0_msb", 32'(sd_o), 1);
    waitEdge(l1 + 2*DIV*(DW-1) - 1);
    checkOutput("A_ws_before_rise", 32'(ws_o), 0);
    waitEdge(l1 + 2*DIV*(DW-1));
    checkOutput("A_ws_rise_slot7", 32'(ws_o), 1);
    checkOutput("A_left_lsb", 32'(sd_o), 1);
    waitEdge(l1 + 2*DIV*(2*DW-1) - 1);
    checkOutput("A_ws_before_fall", 32'(ws_o), 1);
    waitEdge(l1 + 2*DIV*(2*DW-1));
    checkOutput("A_ws_fall_slot15", 32'(ws_o), 0);
    checkOutput("A_right_lsb", 32'(sd_o), 0);
    applyStimulus(8'h81, 8'h18);
    waitEdge(l1 + 4*FRAME);
    checkPhase("A");

    // Backpressure: pairs held back-to-back, then one offered exactly on a load
    startPhase();
    l1 = en_edge + 1;
    for (int i = 0; i < 4; i++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      applyStimulus(a, b);
      if (i == 0) checkOutput("B_ready_low", 32'(ready_o), 0);
    end
    checkOutput("B_acc1", 32'(pushes[1].acc), 32'(l1 + 1));
    checkOutput("B_acc2", 32'(pushes[2].acc), 32'(l1 + 1 + FRAME));
    target = l1 + 5*FRAME;
    waitEdge(target - 1);
    applyStimulus(DW'($urandom), DW'($urandom));
    checkOutput("B_coincide_acc", 32'(pushes[4].acc), 32'(target));
    checkOutput("B_coincide_buffered", 32'(ready_o), 0);
    waitEdge(target + 2*FRAME);
    checkPhase("B");

    // Random pairs with random idle gaps
    startPhase();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 70)) @(negedge clk);
      applyStimulus(DW'($urandom), DW'($urandom));
    end
    waitEdge(cyc + 2*FRAME + 8);
    checkPhase("C");

    // Enable drop mid-frame, then restart with a known pair
    startPhase();
    applyStimulus(8'hFF, DW'($urandom));
    l1 = en_edge + 1;
    waitEdge(l1 + 2*DIV*5 + 1);
    checkOutput("D_pre_drop_sck", 32'(sck_o), 1);
    checkOutput("D_pre_drop_sd", 32'(sd_o), 1);
    en_i = 1'b0;
    @(negedge clk);
    checkOutput("D_drop_sck", 32'(sck_o), 0);
    checkOutput("D_drop_ws", 32'(ws_o), 0);
    checkOutput("D_drop_sd", 32'(sd_o), 0);
    checkOutput("D_drop_frame", 32'(frame_o), 0);
    checkOutput("D_drop_ready", 32'(ready_o), 0);
    startPhase();
    applyStimulus(8'hFF, 8'h00);
    l1 = en_edge + 1;
    waitEdge(l1 + FRAME + 1);
    checkPhase("D");

    // Asynchronous reset while running
    waitEdge(l1 + FRAME + 1);
    checkOutput("E_pre_reset_sck", 32'(sck_o), 1);
    checkOutput("E_pre_reset_sd", 32'(sd_o), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("E_async_sck", 32'(sck_o), 0);
    checkOutput("E_async_ws", 32'(ws_o), 0);
    checkOutput("E_async_sd", 32'(sd_o), 0);
    checkOutput("E_async_frame", 32'(frame_o), 0);
    checkOutput("E_async_underrun", 32'(underrun_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("E_ready_after_release", 32'(ready_o), 1);
    repeat (4) @(negedge clk);
    en_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- I2S transmitter stage directly downstream of the Karplus-Strong string engine inside tt_um_ks_pyamnihc.
- Accepts one stereo sample pair per frame through a valid/ready handshake into a one-entry holding buffer.
- Generates i2s_sck, i2s_ws and i2s_sd in Philips I2S format: ws leads the MSB by one bit, MSB first.
- Reports a per-frame strobe and an underrun flag to the register map and status logic.

Parameters:
- AUDIO_DW, 8, bits per channel.
- SCK_HALF_DIV, 1, clk cycles per sck half-period (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- en_i  in  1  block enable from the config register.
- l_data_i  in  AUDIO_DW  left sample.
- r_data_i  in  AUDIO_DW  right sample.
- valid_i  in  1  upstream sample pair valid.
- ready_o  out  1  holding buffer empty; transfer occurs when valid_i && ready_o.
- sck_o  out  1  I2S bit clock.
- ws_o  out  1  I2S word select; 0 = left, 1 = right.
- sd_o  out  1  I2S serial data.
- frame_o  out  1  one-clk pulse when a new frame word is loaded.
- underrun_o  out  1  one-clk pulse when a frame is loaded with the buffer empty.

Behaviour:
- Reset and en_i=0 state:
  - Reset is asynchronous. Deasserting en_i synchronously returns the block to this same state and clears the buffer.
  - sck_o=0, ws_o=0, sd_o=0, ready_o=1 (0 while en_i=0), frame_o=0, underrun_o=0.
  - div_cnt=0, slot s=2*AUDIO_DW-1, shift word=0, last word=0.
- sck generation:
  - div_cnt counts 0..SCK_HALF_DIV-1 and sck toggles when it wraps.
  - First rising edge comes SCK_HALF_DIV clk cycles after enable; first falling edge after 2*SCK_HALF_DIV cycles.
- Falling event = the clk cycle in which sck goes 1->0. All of ws_o, sd_o and s update only on a falling event, so the receiver samples on sck rising.
- Slot counter:
  - s increments mod 2*AUDIO_DW on each falling event.
  - ws_o = 1 for s in [AUDIO_DW-1, 2*AUDIO_DW-2], else 0. ws therefore changes during the LSB of the preceding channel.
- Frame load, on the falling event that moves s to 0:
  - If the buffer is full: word = {L,R} from the buffer, the buffer empties, and ready_o rises on the next clk.
  - If the buffer is empty: word = last word (repeat) and underrun_o pulses.
  - frame_o pulses in the same cycle as the load.
- Data: sd_o = word[2*AUDIO_DW-1-s], so the left MSB is at slot 0 and the right LSB is at slot 2*AUDIO_DW-1.
- Handshake:
  - A transfer writes the buffer and ready_o drops on the next clk.
  - If a transfer and a frame load coincide, the load takes the old buffer contents and the new pair stays buffered (ready_o stays 0).
  - Pairs offered while ready_o=0 are not taken; upstream must hold valid_i.
- Latency: a pair accepted before a frame load appears on sd_o starting at that load. Worst case is one full frame (2*AUDIO_DW*2*SCK_HALF_DIV clk) plus one frame of buffering.
- Mid-frame effects:
  - en_i falling mid-frame truncates the frame immediately, with no partial flush.
  - Re-enable starts from slot 2*AUDIO_DW-1 with last word 0.

Decomposition:
- Shared package ks_pkg holds:
  - AUDIO_DW default.
  - Slot-count width $clog2(2*AUDIO_DW).
  - WS_RISE_SLOT = AUDIO_DW-1 and FRAME_LAST_SLOT = 2*AUDIO_DW-1.
- One natural sub-module: i2s_sck_gen. It contains the divider and emits sck plus rise/fall event strobes.
- The serializer holds the slot counter, holding buffer and shift logic.

Test Plan:
- Reset: hold rst_n=0 mid-run with en_i=1 -> sck_o/ws_o/sd_o/frame_o/underrun_o all 0 asynchronously, and ready_o=1 after release.
- Basic frame (DW=8, DIV=1): push L=0xA5, R=0x3C before the first load -> frame_o pulses at clk 2.
  - Receiver sampling on sck rising decodes ws=0 word 0xA5 and ws=1 word 0x3C.
  - Frame period is 32 clk.
- ws timing: check ws_o rises on the falling edge starting slot 7 (left LSB) and falls on slot 15 (right LSB). Left MSB (bit 7 of 0xA5 = 1) is on sd_o at slot 0.
- Underrun: after one pair 0x81/0x18, supply nothing -> the next frame repeats 0x81/0x18, underrun_o pulses once per frame, and frame_o still pulses.
- Backpressure:
  - Hold valid_i with 3 pairs queued -> ready_o=0 after the first accept.
  - The second pair is accepted on the cycle after the load; pairs are serialized in order with no loss or duplication.
  - Pair offered in the same cycle as a load -> ends up buffered for the next frame.
- Enable drop: deassert en_i at slot 5 -> outputs 0 on the next clk.
  - Re-enable with pair 0xFF/0x00 -> the first full frame decodes 0xFF/0x00.
